// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared ALU port and the response port.
// master: arbiter side (drives readies, alu_*, rsp_*); slave: environment side.
interface alu_arbiter_if;
   logic       req0_valid;
   logic [2:0] req0_op;
   logic [7:0] req0_a;
   logic [7:0] req0_b;
   logic       req0_ready;
   logic       req1_valid;
   logic [2:0] req1_op;
   logic [7:0] req1_a;
   logic [7:0] req1_b;
   logic       req1_ready;
   logic [2:0] alu_control;
   logic [7:0] alu_src_a;
   logic [7:0] alu_src_b;
   logic [7:0] alu_result;
   logic       alu_zero;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [7:0] rsp_result;
   logic       rsp_zero;
   logic       rsp_err;

   modport master (
      input  req0_valid, req0_op, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req1_ready,
      output alu_control, alu_src_a, alu_src_b,
      input  alu_result, alu_zero,
      output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
      input  rsp_ready
   );

   modport slave (
      output req0_valid, req0_op, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req1_ready,
      input  alu_control, alu_src_a, alu_src_b,
      output alu_result, alu_zero,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
      output rsp_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational 8-bit ALU.
// Ports: clk, rst_n (async active-low), bus (alu_arbiter_if.master).
module alu_arbiter #(
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.master bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0] state;
   logic       last_grant;
   logic       err_q;
   logic       grant;
   logic       pick1;
   logic [2:0] sel_op;
   logic [7:0] sel_a;
   logic [7:0] sel_b;

   // rst_n gates the grant so readies stay low while reset is held.
   always_comb begin
      grant = rst_n & (state == IDLE)
            & (bus.req0_valid | bus.req1_valid);
      pick1 = bus.req1_valid
            & (~bus.req0_valid | (~FIXED_PRIORITY & ~last_grant));
      sel_op = pick1 ? bus.req1_op : bus.req0_op;
      sel_a  = pick1 ? bus.req1_a  : bus.req0_a;
      sel_b  = pick1 ? bus.req1_b  : bus.req0_b;
      bus.req0_ready = grant & ~pick1;
      bus.req1_ready = grant &  pick1;
      bus.rsp_valid  = (state == RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         last_grant      <= 1'b1;
         err_q           <= 1'b0;
         bus.rsp_id      <= 1'b0;
         bus.rsp_result  <= 8'h00;
         bus.rsp_zero    <= 1'b0;
         bus.rsp_err     <= 1'b0;
         bus.alu_control <= 3'd0;
         bus.alu_src_a   <= 8'h00;
         bus.alu_src_b   <= 8'h00;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant) begin
                  state         <= EXEC;
                  last_grant    <= pick1;
                  bus.rsp_id    <= pick1;
                  err_q         <= (sel_op >= 3'd5);
                  // Illegal opcodes leave the ALU opcode untouched.
                  if (sel_op < 3'd5)
                     bus.alu_control <= sel_op;
                  bus.alu_src_a <= sel_a;
                  bus.alu_src_b <= sel_b;
               end
            end
            EXEC: begin
               bus.rsp_result <= err_q ? 8'h00 : bus.alu_result;
               bus.rsp_zero   <= err_q | bus.alu_zero;
               bus.rsp_err    <= err_q;
               state          <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: round-robin and fixed-priority DUTs
// sharing clk/rst_n, each with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   typedef struct packed {
      logic       id;
      logic [7:0] res;
      logic       zero;
      logic       err;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1, g0, g1;

   always #5 clk = ~clk;

   alu_arbiter_if bus();
   alu_arbiter_if bus_fp();

   alu_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   alu_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
      .clk(clk), .rst_n(rst_n), .bus(bus_fp));

   function automatic logic [7:0] alu_f(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return ~a;
         3'd4: return (a == 8'h00) ? 8'h01 : 8'h00;
         default: return 8'hA5;
      endcase
   endfunction

   assign bus.alu_result = alu_f(bus.alu_control, bus.alu_src_a, bus.alu_src_b);
   assign bus.alu_zero   = (bus.alu_result == 8'h00);
   assign bus_fp.alu_result = alu_f(bus_fp.alu_control, bus_fp.alu_src_a,
                                    bus_fp.alu_src_b);
   assign bus_fp.alu_zero   = (bus_fp.alu_result == 8'h00);

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.rsp_valid && bus.rsp_ready) begin
         checks++;
         g0 = exp_t'{bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_err};
         if (q0.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected got=%h exp=none", g0);
         end else begin
            e0 = q0.pop_front();
            if (g0 !== e0) begin
               failures++;
               $display("FAIL rsp got=%h exp=%h", g0, e0);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus_fp.rsp_valid && bus_fp.rsp_ready) begin
         checks++;
         g1 = exp_t'{bus_fp.rsp_id, bus_fp.rsp_result, bus_fp.rsp_zero,
                     bus_fp.rsp_err};
         if (q1.size() == 0) begin
            failures++;
            $display("FAIL rsp_fp_unexpected got=%h exp=none", g1);
         end else begin
            e1 = q1.pop_front();
            if (g1 !== e1) begin
               failures++;
               $display("FAIL rsp_fp got=%h exp=%h", g1, e1);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit fp, input bit id, input logic v,
                          input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b);
      if (!fp && !id) begin
         bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end else if (!fp) begin
         bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end else if (!id) begin
         bus_fp.req0_valid = v; bus_fp.req0_op = op;
         bus_fp.req0_a = a; bus_fp.req0_b = b;
      end else begin
         bus_fp.req1_valid = v; bus_fp.req1_op = op;
         bus_fp.req1_a = a; bus_fp.req1_b = b;
      end
   endtask

   task automatic wait_grant(input bit fp, output bit ok,
                             output logic [1:0] rdy);
      ok = 1'b0;
      rdy = 2'b00;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rdy = fp ? {bus_fp.req1_ready, bus_fp.req0_ready}
                  : {bus.req1_ready, bus.req0_ready};
         if (rdy != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input bit fp);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!fp && !bus.rsp_valid && q0.size() == 0) break;
         if (fp && !bus_fp.rsp_valid && q1.size() == 0) break;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      set_req(0, 0, 1'b1, 3'd0, 8'h11, 8'h22);
      set_req(1, 1, 1'b1, 3'd0, 8'h11, 8'h22);
      @(negedge clk);
      checks++;
      if ({bus.req0_ready, bus.req1_ready,
           bus_fp.req0_ready, bus_fp.req1_ready} !== 4'b0000) begin
         failures++;
         $display("FAIL rst_ready got=%b exp=0000",
                  {bus.req0_ready, bus.req1_ready,
                   bus_fp.req0_ready, bus_fp.req1_ready});
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_zero,
           bus.rsp_err} !== 12'h000) begin
         failures++;
         $display("FAIL rst_rsp got=%h exp=000",
                  {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_zero,
                   bus.rsp_err});
      end
      checks++;
      if ({bus.alu_control, bus.alu_src_a, bus.alu_src_b} !== 19'h0) begin
         failures++;
         $display("FAIL rst_alu got=%h exp=0",
                  {bus.alu_control, bus.alu_src_a, bus.alu_src_b});
      end
      set_req(0, 0, 1'b0, 3'd0, 8'h00, 8'h00);
      set_req(1, 1, 1'b0, 3'd0, 8'h00, 8'h00);
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      bit ok;
      logic [1:0] rdy;
      tick;
      set_req(0, 0, 1'b1, 3'd0, 8'hF0, 8'h20);
      wait_grant(0, ok, rdy);
      checks++;
      if (!ok || rdy !== 2'b01) begin
         failures++;
         $display("FAIL single_grant got=%b exp=01", rdy);
      end
      q0.push_back(exp_t'{1'b0, 8'h10, 1'b0, 1'b0});
      tick;
      set_req(0, 0, 1'b0, 3'd7, 8'hFF, 8'hFF);
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.req0_ready, bus.alu_control, bus.alu_src_a,
           bus.alu_src_b} !== {2'b00, 3'd0, 8'hF0, 8'h20}) begin
         failures++;
         $display("FAIL single_exec got=%h exp=%h",
                  {bus.rsp_valid, bus.req0_ready, bus.alu_control,
                   bus.alu_src_a, bus.alu_src_b},
                  {2'b00, 3'd0, 8'hF0, 8'h20});
      end
      tick;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL single_latency got=%b exp=1", bus.rsp_valid);
      end
      wait_idle(0);
   endtask

   task automatic test_round_robin;
      bit ok;
      logic [1:0] rdy;
      tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      set_req(0, 0, 1'b1, 3'd1, 8'h05, 8'h05);
      set_req(0, 1, 1'b1, 3'd2, 8'h0F, 8'hF0);
      for (int g = 0; g < 3; g++) begin
         wait_grant(0, ok, rdy);
         checks++;
         if (!ok || rdy !== ((g == 1) ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL rr_grant%0d got=%b exp=%b", g, rdy,
                     (g == 1) ? 2'b10 : 2'b01);
         end
         q0.push_back(exp_t'{(g == 1), 8'h00, 1'b1, 1'b0});
         tick;
      end
      set_req(0, 0, 1'b0, 3'd0, 8'h00, 8'h00);
      set_req(0, 1, 1'b0, 3'd0, 8'h00, 8'h00);
      wait_idle(0);
   endtask

   task automatic test_err;
      bit ok;
      logic [1:0] rdy;
      tick;
      set_req(0, 1, 1'b1, 3'd6, 8'h33, 8'h44);
      wait_grant(0, ok, rdy);
      checks++;
      if (!ok || rdy !== 2'b10) begin
         failures++;
         $display("FAIL err_grant got=%b exp=10", rdy);
      end
      q0.push_back(exp_t'{1'b1, 8'h00, 1'b1, 1'b1});
      tick;
      set_req(0, 1, 1'b0, 3'd0, 8'h00, 8'h00);
      @(negedge clk);
      checks++;
      if (bus.alu_control !== 3'd1) begin
         failures++;
         $display("FAIL err_alu_hold got=%0d exp=1", bus.alu_control);
      end
      wait_idle(0);
   endtask

   task automatic test_stall;
      bit ok;
      logic [1:0] rdy;
      tick;
      bus.rsp_ready = 1'b0;
      set_req(0, 0, 1'b1, 3'd0, 8'h01, 8'h02);
      wait_grant(0, ok, rdy);
      checks++;
      if (!ok || rdy !== 2'b01) begin
         failures++;
         $display("FAIL stall_grant got=%b exp=01", rdy);
      end
      q0.push_back(exp_t'{1'b0, 8'h03, 1'b0, 1'b0});
      tick;
      set_req(0, 0, 1'b1, 3'd2, 8'hAA, 8'h55);
      set_req(0, 1, 1'b1, 3'd1, 8'h77, 8'h11);
      @(negedge clk);
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
         failures++;
         $display("FAIL stall_exec_ready got=%b exp=00",
                  {bus.req1_ready, bus.req0_ready});
      end
      for (int i = 0; i < 5; i++) begin
         tick;
         @(negedge clk);
         checks++;
         if ({bus.rsp_valid, bus.req1_ready, bus.req0_ready, bus.rsp_id,
              bus.rsp_result, bus.rsp_zero, bus.rsp_err}
             !== {4'b1000, 8'h03, 2'b00}) begin
            failures++;
            $display("FAIL stall_hold%0d got=%h exp=%h", i,
                     {bus.rsp_valid, bus.req1_ready, bus.req0_ready,
                      bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_err},
                     {4'b1000, 8'h03, 2'b00});
         end
      end
      tick;
      set_req(0, 0, 1'b0, 3'd0, 8'h00, 8'h00);
      set_req(0, 1, 1'b0, 3'd0, 8'h00, 8'h00);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      tick;
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 3'b000) begin
         failures++;
         $display("FAIL stall_release got=%b exp=000",
                  {bus.rsp_valid, bus.req1_ready, bus.req0_ready});
      end
   endtask

   task automatic test_reset_exec;
      bit ok;
      logic [1:0] rdy;
      tick;
      set_req(0, 0, 1'b1, 3'd3, 8'h00, 8'h00);
      wait_grant(0, ok, rdy);
      checks++;
      if (!ok || rdy !== 2'b01) begin
         failures++;
         $display("FAIL rst_exec_grant got=%b exp=01", rdy);
      end
      tick;
      set_req(0, 0, 1'b0, 3'd0, 8'h00, 8'h00);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id,
           bus.rsp_result, bus.rsp_zero, bus.rsp_err, bus.alu_control,
           bus.alu_src_a, bus.alu_src_b} !== 35'h0) begin
         failures++;
         $display("FAIL rst_exec_clear got=%h exp=0",
                  {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id,
                   bus.rsp_result, bus.rsp_zero, bus.rsp_err, bus.alu_control,
                   bus.alu_src_a, bus.alu_src_b});
      end
      tick;
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_rsp%0d got=%b exp=0", i, bus.rsp_valid);
         end
      end
      tick;
      set_req(0, 0, 1'b1, 3'd0, 8'h02, 8'h03);
      set_req(0, 1, 1'b1, 3'd1, 8'h09, 8'h04);
      wait_grant(0, ok, rdy);
      checks++;
      if (!ok || rdy !== 2'b01) begin
         failures++;
         $display("FAIL rst_first_grant got=%b exp=01", rdy);
      end
      q0.push_back(exp_t'{1'b0, 8'h05, 1'b0, 1'b0});
      tick;
      set_req(0, 0, 1'b0, 3'd0, 8'h00, 8'h00);
      set_req(0, 1, 1'b0, 3'd0, 8'h00, 8'h00);
      wait_idle(0);
   endtask

   task automatic test_fixed;
      bit ok;
      logic [1:0] rdy;
      tick;
      set_req(1, 0, 1'b1, 3'd4, 8'h00, 8'h00);
      set_req(1, 1, 1'b1, 3'd0, 8'h11, 8'h22);
      for (int g = 0; g < 3; g++) begin
         wait_grant(1, ok, rdy);
         checks++;
         if (!ok || rdy !== 2'b01) begin
            failures++;
            $display("FAIL fixed_grant%0d got=%b exp=01", g, rdy);
         end
         q1.push_back(exp_t'{1'b0, 8'h01, 1'b0, 1'b0});
         tick;
      end
      set_req(1, 0, 1'b0, 3'd0, 8'h00, 8'h00);
      set_req(1, 1, 1'b0, 3'd0, 8'h00, 8'h00);
      wait_idle(1);
   endtask

   task automatic test_drain;
      repeat (3) @(negedge clk);
      checks++;
      if (q0.size() != 0) begin
         failures++;
         $display("FAIL drain_q0 got=%0d exp=0", q0.size());
      end
      checks++;
      if (q1.size() != 0) begin
         failures++;
         $display("FAIL drain_q1 got=%0d exp=0", q1.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.rsp_ready = 1'b1;
      bus_fp.rsp_ready = 1'b1;
      set_req(0, 0, 1'b0, 3'd0, 8'h00, 8'h00);
      set_req(0, 1, 1'b0, 3'd0, 8'h00, 8'h00);
      set_req(1, 0, 1'b0, 3'd0, 8'h00, 8'h00);
      set_req(1, 1, 1'b0, 3'd0, 8'h00, 8'h00);
      test_reset;
      test_single;
      test_round_robin;
      test_err;
      test_stall;
      test_reset_exec;
      test_fixed;
      test_drain;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

endmodule
